irq_pending_latch: RTL and testbench

Upstream stage for the 4-to-2 priority encoder. Captures rising edges on N asynchronous-event request lines, holds them as sticky pending bits until acknowledged, and applies a per-line mask. Its registered, masked pending vector drives the encoder's `a` input directly. The encoder's `y` output returns through `ack_idx` to clear the serviced bit.

---
 rtl/irq_pending_latch.sv | 79 +++++++
 tb/tb_irq_pending_latch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Sticky, maskable interrupt pending latch feeding the priority encoder.
// Define IRQ_SYNC_EN to pass req through a 2-flop synchronizer before edge detection.
module irq_pending_latch #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          mask_we,
  input  logic [N-1:0]  mask_in,
  input  logic          ack,
  input  logic [IW-1:0] ack_idx,
  output logic [N-1:0]  pend,
  output logic          irq,
  output logic [N-1:0]  overflow,
  output logic [N-1:0]  pend_raw
);

  logic [N-1:0] sync_req;
  logic [N-1:0] req_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] mask_q;
  logic [N-1:0] ovf_q;
  logic [N-1:0] rise;
  logic [N-1:0] clr;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req;
      sync2_q <= sync1_q;
    end
  end

  assign sync_req = sync2_q;
`else
  assign sync_req = req;
`endif

  // Index values >= N never match a loop index, so out-of-range acks fall away.
  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      clr[i] = ack && (ack_idx == IW'(i));
    end
  end

  assign rise = sync_req & ~req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      ovf_q  <= '0;
    end else begin
      req_q  <= sync_req;
      // A new edge outranks a same-cycle acknowledge.
      pend_q <= rise | (pend_q & ~clr);
      ovf_q  <= (rise & pend_q & ~clr) | (ovf_q & ~(clr & ~rise));
      if (mask_we) begin
        mask_q <= mask_in;
      end
    end
  end

  assign pend     = pend_q & ~mask_q;
  assign irq      = |pend;
  assign overflow = ovf_q;
  assign pend_raw = pend_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed and randomized checks of irq_pending_latch against an event-level model.
module tb_irq_pending_latch;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          mask_we;
  logic [N-1:0]  mask_in;
  logic          ack;
  logic [IW-1:0] ack_idx;
  logic [N-1:0]  pend;
  logic          irq;
  logic [N-1:0]  overflow;
  logic [N-1:0]  pend_raw;

  int checks = 0;
  int errors = 0;

  // Reference model state: one pending/overflow flag per line.
  logic [N-1:0] m_pend, m_ovf, m_prev, m_mask, m_s1, m_s2;

  irq_pending_latch #(.N(N), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mask_we  (mask_we),
    .mask_in  (mask_in),
    .ack      (ack),
    .ack_idx  (ack_idx),
    .pend     (pend),
    .irq      (irq),
    .overflow (overflow),
    .pend_raw (pend_raw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int top_index(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_edge();
    logic [N-1:0] eff;
    bit new_evt, hit;
    if (rst) begin
      m_pend = '0; m_ovf = '0; m_prev = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;
    end else begin
`ifdef IRQ_SYNC_EN
      eff = m_s2; m_s2 = m_s1; m_s1 = req;
`else
      eff = req;
`endif
      for (int i = 0; i < N; i++) begin
        new_evt = eff[i] && !m_prev[i];
        hit     = ack && (int'(ack_idx) == i);
        if (new_evt) begin
          if (m_pend[i] && !hit) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (hit) begin
          m_pend[i] = 1'b0;
          m_ovf[i]  = 1'b0;
        end
      end
      m_prev = eff;
      if (mask_we) m_mask = mask_in;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("model_pend", pend, m_pend & ~m_mask);
      check("model_irq", {3'b000, irq}, {3'b000, |(m_pend & ~m_mask)});
      check("model_overflow", overflow, m_ovf);
      check("model_pend_raw", pend_raw, m_pend);
    end
  endtask

  task automatic do_ack(input int idx);
    ack = 1'b1; ack_idx = IW'(idx);
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; mask_we = 1'b0; mask_in = '0; ack = 1'b0; ack_idx = '0;
    m_pend = '0; m_ovf = '0; m_prev = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;

    // Reset with all requests high, then release.
    tick();
    check("rst_pend_0", pend, 4'b0000);
    tick();
    check("rst_irq", {3'b000, irq}, 4'b0000);
    rst = 1'b0;
    tick(LAT);
    check("post_rst_pend", pend, 4'b1111);
    check("post_rst_irq", {3'b000, irq}, 4'b0001);
    check("post_rst_enc_y", 4'(top_index(pend)), 4'd3);
    req = '0;
    for (int i = N - 1; i >= 0; i--) do_ack(i);
    check("drain_pend", pend, 4'b0000);
    tick(LAT);

    // Single event and acknowledge.
    req = 4'b0010;
    tick(LAT);
    check("single_pend", pend, 4'b0010);
    do_ack(1);
    check("single_ack_pend", pend, 4'b0000);
    check("single_ack_irq", {3'b000, irq}, 4'b0000);
    tick(4);
    check("single_hold_high", pend, 4'b0000);
    req = '0;
    tick(LAT + 1);

    // New edge and acknowledge on the same line in one cycle.
    req = 4'b0100;
    tick(LAT);
    check("simul_first", pend, 4'b0100);
    req = '0;
    tick(LAT);
    req = 4'b0100;
    if (LAT > 1) tick(LAT - 1);
    do_ack(2);
    check("simul_pend2", {3'b000, pend[2]}, 4'b0001);
    check("simul_ovf2", {3'b000, overflow[2]}, 4'b0000);
    do_ack(2);
    req = '0;
    tick(LAT + 1);

    // Two events on line 0 without service.
    req = 4'b0001; tick(LAT);
    req = 4'b0000; tick(LAT);
    req = 4'b0001; tick(LAT);
    check("ovf_set", overflow, 4'b0001);
    check("ovf_pend", pend, 4'b0001);
    do_ack(0);
    check("ovf_clr_pend", pend, 4'b0000);
    check("ovf_clr_ovf", overflow, 4'b0000);
    req = '0;
    tick(LAT + 1);

    // Masked capture and unmask.
    mask_we = 1'b1; mask_in = 4'b1000;
    tick();
    mask_we = 1'b0;
    req = 4'b1000;
    tick(LAT);
    check("mask_pend", pend, 4'b0000);
    check("mask_pend_raw", pend_raw, 4'b1000);
    check("mask_irq", {3'b000, irq}, 4'b0000);
    mask_we = 1'b1; mask_in = 4'b0000;
    tick();
    mask_we = 1'b0;
    check("unmask_pend", pend, 4'b1000);
    do_ack(3);
    req = '0;
    tick(LAT + 1);

    // Ack of a non-pending bit, then reset mid-operation.
    req = 4'b0110;
    tick(LAT);
    check("inv_setup", pend, 4'b0110);
    do_ack(0);
    check("inv_ack_pend", pend, 4'b0110);
    rst = 1'b1;
    tick();
    check("midrst_pend", pend, 4'b0000);
    check("midrst_ovf", overflow, 4'b0000);
    rst = 1'b0; req = '0;
    tick(LAT + 1);

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      ack = ($urandom_range(0, 3) == 0);
      ack_idx = ($urandom_range(0, 1) == 0) ? IW'(top_index(pend)) : IW'($urandom_range(0, N - 1));
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = N'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; ack = 1'b0; mask_we = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
